// File: rtl/portcullis_pkg.sv
// rtl/portcullis_pkg.sv - shared state and direction definitions for the portcullis controller
//
// Purpose : per-gate FSM state encoding and motor direction constants used
//           by portcullis_gate and portcullis_ctrl_multi.
// Ports   : none (package).

package portcullis_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_RAISE = 3'd1,
    ST_CLOSE = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FAULT = 3'd4
  } gate_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DW = 1'b0;

endpackage

// File: rtl/portcullis_gate.sv
// rtl/portcullis_gate.sv - single-channel portcullis raise/lower FSM with dead-time and timeout
//
// Purpose : one gate channel. It detects button presses by their rising edge,
//           enforces a motor dead-time before any reversal, faults on travel
//           timeout or on an impossible limit-switch pair, and latches the fault
//           until it is cleared.
// Ports   :
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   a          in   operator button level (debounced)
//   up_lmt     in   upper limit switch, 1 = fully raised
//   dw_lmt     in   lower limit switch, 1 = fully closed
//   clr_fault  in   fault clear level
//   mot_up     out  raise motor drive
//   mot_dw     out  lower motor drive
//   fault      out  latched fault

module portcullis_gate
  import portcullis_pkg::*;
#(
  parameter int DEAD_TIME      = 8,
  parameter int TRAVEL_TIMEOUT = 1000,
  parameter int CNT_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic up_lmt,
  input  logic dw_lmt,
  input  logic clr_fault,
  output logic mot_up,
  output logic mot_dw,
  output logic fault
);

  localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

  gate_state_e      state;
  logic [CNT_W-1:0] timer;
  logic             a_q;
  logic             pend_dir;

  logic a_rise;
  logic both_lmt;
  logic pend_lmt;

  assign a_rise   = a & ~a_q;
  assign both_lmt = up_lmt & dw_lmt;
  // Limit switch that would immediately stop the move PAUSE is waiting to start.
  assign pend_lmt = (pend_dir == DIR_UP) ? up_lmt : dw_lmt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_WAIT;
      timer    <= '0;
      a_q      <= 1'b1;   // a button held through reset must not count as a press
      pend_dir <= DIR_UP;
    end else begin
      a_q <= a;
      // Every branch that changes state overrides this with a clear.
      if (timer != TIMER_MAX) timer <= timer + 1'b1;

      case (state)
        ST_WAIT: begin
          if (both_lmt) begin
            state <= ST_FAULT; timer <= '0;
          end else if (a_rise) begin
            state <= up_lmt ? ST_CLOSE : ST_RAISE; timer <= '0;
          end
        end
        ST_RAISE: begin
          if (both_lmt) begin
            state <= ST_FAULT; timer <= '0;
          end else if (up_lmt) begin
            state <= ST_WAIT; timer <= '0;
          end else if (timer == TRAVEL_LAST) begin
            state <= ST_FAULT; timer <= '0;
          end else if (a_rise) begin
            state <= ST_PAUSE; timer <= '0; pend_dir <= DIR_DW;
          end
        end
        ST_CLOSE: begin
          if (both_lmt) begin
            state <= ST_FAULT; timer <= '0;
          end else if (dw_lmt) begin
            state <= ST_WAIT; timer <= '0;
          end else if (timer == TRAVEL_LAST) begin
            state <= ST_FAULT; timer <= '0;
          end else if (a_rise) begin
            state <= ST_PAUSE; timer <= '0; pend_dir <= DIR_UP;
          end
        end
        ST_PAUSE: begin
          // Presses are ignored here so the dead-time cannot be cut short.
          if (both_lmt) begin
            state <= ST_FAULT; timer <= '0;
          end else if (pend_lmt) begin
            state <= ST_WAIT; timer <= '0;
          end else if (timer == DEAD_LAST) begin
            state <= (pend_dir == DIR_UP) ? ST_RAISE : ST_CLOSE; timer <= '0;
          end
        end
        ST_FAULT: begin
          if (clr_fault && !both_lmt) begin
            state <= ST_WAIT; timer <= '0;
          end
        end
        default: begin
          state <= ST_WAIT; timer <= '0;
        end
      endcase
    end
  end

  // Moore decode of the state register; unknown encodings drive nothing.
  assign mot_up = (state == ST_RAISE);
  assign mot_dw = (state == ST_CLOSE);
  assign fault  = (state == ST_FAULT);

endmodule

// File: rtl/portcullis_ctrl_multi.sv
// rtl/portcullis_ctrl_multi.sv - N-channel portcullis controller top level
//
// Purpose : N_GATES independent portcullis_gate channels plus a summary fault.
// Ports   :
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   A          in   [N_GATES] operator buttons, rising edge acts
//   UP_LMT     in   [N_GATES] upper limit switches
//   DW_LMT     in   [N_GATES] lower limit switches
//   CLR_FAULT  in   [N_GATES] fault clears
//   MOT_UP     out  [N_GATES] raise motor drives
//   MOT_DW     out  [N_GATES] lower motor drives
//   FAULT      out  [N_GATES] latched faults
//   ANY_FAULT  out  OR of FAULT

module portcullis_ctrl_multi
  import portcullis_pkg::*;
#(
  parameter int N_GATES        = 2,
  parameter int DEAD_TIME      = 8,
  parameter int TRAVEL_TIMEOUT = 1000,
  parameter int CNT_W          = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_GATES-1:0] A,
  input  logic [N_GATES-1:0] UP_LMT,
  input  logic [N_GATES-1:0] DW_LMT,
  input  logic [N_GATES-1:0] CLR_FAULT,
  output logic [N_GATES-1:0] MOT_UP,
  output logic [N_GATES-1:0] MOT_DW,
  output logic [N_GATES-1:0] FAULT,
  output logic               ANY_FAULT
);

  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    portcullis_gate #(
      .DEAD_TIME      (DEAD_TIME),
      .TRAVEL_TIMEOUT (TRAVEL_TIMEOUT),
      .CNT_W          (CNT_W)
    ) u_gate (
      .clk       (clk),
      .rst       (rst),
      .a         (A[g]),
      .up_lmt    (UP_LMT[g]),
      .dw_lmt    (DW_LMT[g]),
      .clr_fault (CLR_FAULT[g]),
      .mot_up    (MOT_UP[g]),
      .mot_dw    (MOT_DW[g]),
      .fault     (FAULT[g])
    );
  end

  assign ANY_FAULT = |FAULT;

endmodule

// File: tb/tb_portcullis_ctrl_multi.sv
// tb/tb_portcullis_ctrl_multi.sv - self-checking bench for portcullis_ctrl_multi

module tb_portcullis_ctrl_multi;

  localparam int NG = 2;
  localparam int DT = 4;
  localparam int TT = 16;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [NG-1:0] A, UP_LMT, DW_LMT, CLR_FAULT;
  logic [NG-1:0] MOT_UP, MOT_DW, FAULT;
  logic          ANY_FAULT;

  always #5 clk = ~clk;

  portcullis_ctrl_multi #(
    .N_GATES(NG), .DEAD_TIME(DT), .TRAVEL_TIMEOUT(TT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .A(A), .UP_LMT(UP_LMT), .DW_LMT(DW_LMT),
    .CLR_FAULT(CLR_FAULT), .MOT_UP(MOT_UP), .MOT_DW(MOT_DW),
    .FAULT(FAULT), .ANY_FAULT(ANY_FAULT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what each gate is doing and how long it has been doing it.
  typedef enum int {M_IDLE, M_GO_UP, M_GO_DOWN, M_DEAD, M_ERR} activity_e;
  activity_e act_m[NG];
  int        spent[NG];     // completed cycles in the current activity
  bit        last_a[NG];
  bit        after_up[NG];  // dead-time will be followed by raising

  task automatic model_step();
    for (int g = 0; g < NG; g++) begin
      activity_e nxt;
      bit press, both, up, dw;
      up    = UP_LMT[g];
      dw    = DW_LMT[g];
      press = A[g] && !last_a[g];
      both  = up && dw;
      if (rst) begin
        act_m[g] = M_IDLE; spent[g] = 0; last_a[g] = 1'b1;
      end else begin
        last_a[g] = A[g];
        nxt = act_m[g];
        if (act_m[g] != M_ERR && both) nxt = M_ERR;
        else case (act_m[g])
          M_IDLE:    if (press) nxt = up ? M_GO_DOWN : M_GO_UP;
          M_GO_UP:   if (up) nxt = M_IDLE;
                     else if (spent[g] + 1 >= TT) nxt = M_ERR;
                     else if (press) begin nxt = M_DEAD; after_up[g] = 1'b0; end
          M_GO_DOWN: if (dw) nxt = M_IDLE;
                     else if (spent[g] + 1 >= TT) nxt = M_ERR;
                     else if (press) begin nxt = M_DEAD; after_up[g] = 1'b1; end
          M_DEAD:    if (after_up[g] ? up : dw) nxt = M_IDLE;
                     else if (spent[g] + 1 >= DT) nxt = after_up[g] ? M_GO_UP : M_GO_DOWN;
          M_ERR:     if (CLR_FAULT[g] && !both) nxt = M_IDLE;
          default:   nxt = M_IDLE;
        endcase
        if (nxt != act_m[g]) spent[g] = 0; else spent[g]++;
        act_m[g] = nxt;
      end
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [1:0] u, d, f;
    for (int g = 0; g < NG; g++) begin
      u[g] = (act_m[g] == M_GO_UP);
      d[g] = (act_m[g] == M_GO_DOWN);
      f[g] = (act_m[g] == M_ERR);
    end
    return {u, d, f, |f};
  endfunction

  task automatic cyc(input bit r, input logic [1:0] a, input logic [1:0] up,
                     input logic [1:0] dw, input logic [1:0] clr);
    rst = r; A = a; UP_LMT = up; DW_LMT = dw; CLR_FAULT = clr;
    @(posedge clk);
    model_step();
    #1;
    check("model", {1'b0, MOT_UP, MOT_DW, FAULT, ANY_FAULT}, {1'b0, model_out()});
  endtask

  typedef struct {
    bit         r;
    logic [1:0] a, up, dw, clr;
    logic [1:0] e_up, e_dw, e_flt;
  } vec_t;

  vec_t tv[19];
  int   cnt;
  int   guard;

  initial begin
    rst = 1'b1; A = '0; UP_LMT = '0; DW_LMT = '0; CLR_FAULT = '0;

    // Basic raise, then reversal through the dead-time (gate 0 only).
    tv[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[2]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[3]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[4]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[5]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[7]  = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[8]  = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[9]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[10] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[11] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[12] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[13] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[14] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    tv[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    tv[17] = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[18] = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    for (int i = 0; i < 19; i++) begin
      cyc(tv[i].r, tv[i].a, tv[i].up, tv[i].dw, tv[i].clr);
      check($sformatf("vec%0d", i), {2'b00, MOT_UP, MOT_DW, FAULT},
            {2'b00, tv[i].e_up, tv[i].e_dw, tv[i].e_flt});
    end

    // Travel timeout on gate 1: exactly TT cycles of drive, then a latched fault.
    cyc(0, 2'b10, 2'b00, 2'b00, 2'b00);
    cnt = 0; guard = 0;
    while (FAULT[1] !== 1'b1 && guard < 3 * TT) begin
      if (MOT_UP[1]) cnt++;
      cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);
      guard++;
    end
    check("timeout_drive_cycles", 8'(cnt), 8'(TT));
    check("timeout_fault", {6'b0, FAULT[1], ANY_FAULT}, 8'b11);
    cyc(0, 2'b10, 2'b00, 2'b00, 2'b00);
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);
    check("fault_ignores_press", {5'b0, MOT_UP[1], MOT_DW[1], FAULT[1]}, 8'b001);
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b10);
    check("fault_cleared", {6'b0, FAULT[1], ANY_FAULT}, 8'b00);
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Both limits high on gate 0.
    cyc(0, 2'b00, 2'b01, 2'b01, 2'b00);
    check("both_lmt_fault", {7'b0, FAULT[0]}, 8'd1);
    cyc(0, 2'b00, 2'b01, 2'b01, 2'b01);
    check("clear_blocked", {7'b0, FAULT[0]}, 8'd1);
    cyc(0, 2'b00, 2'b01, 2'b00, 2'b01);
    check("clear_ok", {7'b0, FAULT[0]}, 8'd0);
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Button held through reset, then a real press; reset in the middle of CLOSE.
    cyc(1, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) cyc(0, 2'b01, 2'b00, 2'b00, 2'b00);
    check("held_through_reset", {6'b0, MOT_UP[0], MOT_DW[0]}, 8'b00);
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(0, 2'b01, 2'b00, 2'b00, 2'b00);
    check("press_after_reset", {6'b0, MOT_UP[0], MOT_DW[0]}, 8'b10);
    cyc(0, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc(0, 2'b01, 2'b01, 2'b00, 2'b00);
    check("press_at_top_closes", {6'b0, MOT_UP[0], MOT_DW[0]}, 8'b01);
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1, 2'b00, 2'b00, 2'b00, 2'b00);
    check("reset_mid_close", {6'b0, MOT_UP[0], MOT_DW[0]}, 8'b00);

    // Limit and press in the same cycle: the limit wins, no dead-time follows.
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(0, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(0, 2'b01, 2'b01, 2'b00, 2'b00);
    check("limit_beats_press", {6'b0, MOT_UP[0], MOT_DW[0]}, 8'b00);
    for (int i = 0; i < DT + 2; i++) cyc(0, 2'b00, 2'b01, 2'b00, 2'b00);
    check("no_reversal_after_limit", {6'b0, MOT_UP[0], MOT_DW[0]}, 8'b00);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] ra, ru, rd, rc;
      bit         rr;
      rr = ($urandom_range(0, 299) == 0);
      for (int g = 0; g < NG; g++) begin
        ra[g] = ($urandom_range(0, 5) == 0) ? ~A[g] : A[g];
        ru[g] = ($urandom_range(0, 14) == 0);
        rd[g] = ($urandom_range(0, 14) == 0);
        rc[g] = ($urandom_range(0, 19) == 0);
      end
      cyc(rr, ra, ru, rd, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
